// File: rtl/vga_timing_sink.sv
// Receive-side VGA stream monitor: recovers pixel coordinates, measures line/frame timing,
// accumulates a per-frame colour checksum and reports lock once consecutive frames agree.
module vga_timing_sink #(
  parameter int CDW             = 10,
  parameter int CW              = 12,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           hsync,
  input  logic           vsync,
  input  logic [CDW-1:0] red,
  input  logic [CDW-1:0] green,
  input  logic [CDW-1:0] blue,
  input  logic           pxlen,
  input  logic           active,
  output logic           pix_valid,
  output logic [CW-1:0]  pix_x,
  output logic [CW-1:0]  pix_y,
  output logic           frame_done,
  output logic [CW-1:0]  h_total,
  output logic [CW-1:0]  h_active,
  output logic [CW-1:0]  v_total,
  output logic [CW-1:0]  v_active,
  output logic [31:0]    checksum,
  output logic           locked,
  output logic           mismatch,
  output logic           overflow
);

  typedef enum logic [1:0] {SEEK, ACQ, LOCK} state_t;

  localparam logic [CW-1:0] MAX = '1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_hs_prev;
  logic          r_vs_prev;
  logic [CW-1:0] r_hcnt;
  logic [CW-1:0] r_acnt;
  logic [CW-1:0] r_ycnt;
  logic [CW-1:0] r_vcnt;
  logic [CW-1:0] r_line_h;
  logic [CW-1:0] r_line_a;
  logic [31:0]   r_csum;
  logic          r_frame_ovf;
  logic          r_have_prev;

  logic          w_hs_lvl;
  logic          w_vs_lvl;
  logic          w_hs_edge;
  logic          w_vs_edge;
  logic          w_pix;
  logic          w_line_act;
  logic [CW-1:0] w_hcnt_nxt;
  logic [CW-1:0] w_acnt_nxt;
  logic [CW-1:0] w_ycnt_nxt;
  logic [CW-1:0] w_vcnt_nxt;
  logic          w_sat;
  logic [31:0]   w_pix_sum;
  logic [31:0]   w_csum_nxt;
  logic          w_frame_ovf;
  logic          w_same;
  logic          w_qual;
  logic          w_latch;
  logic          w_mismatch;

  // Work internally with "asserted" levels so the polarity parameter only touches these two lines.
  assign w_hs_lvl   = SYNC_ACTIVE_LOW ? ~hsync : hsync;
  assign w_vs_lvl   = SYNC_ACTIVE_LOW ? ~vsync : vsync;
  assign w_hs_edge  = w_hs_lvl & ~r_hs_prev;
  assign w_vs_edge  = w_vs_lvl & ~r_vs_prev;
  assign w_pix      = pxlen & active;
  assign w_line_act = (r_acnt != '0);
  assign w_pix_sum  = 32'(red) + 32'(green) + 32'(blue);

  always_comb begin
    w_sat      = 1'b0;
    w_hcnt_nxt = r_hcnt;
    w_acnt_nxt = r_acnt;
    w_ycnt_nxt = r_ycnt;
    w_vcnt_nxt = r_vcnt;
    if (w_hs_edge) begin
      // A strobe coincident with the edge is the first pixel of the new line.
      w_hcnt_nxt = {{(CW-1){1'b0}}, pxlen};
      w_acnt_nxt = {{(CW-1){1'b0}}, w_pix};
      if (w_line_act) begin
        if (r_ycnt == MAX) w_sat = 1'b1;
        else               w_ycnt_nxt = r_ycnt + 1'b1;
      end
      if (r_vcnt == MAX) w_sat = 1'b1;
      else               w_vcnt_nxt = r_vcnt + 1'b1;
    end else begin
      if (pxlen) begin
        if (r_hcnt == MAX) w_sat = 1'b1;
        else               w_hcnt_nxt = r_hcnt + 1'b1;
      end
      if (w_pix) begin
        if (r_acnt == MAX) w_sat = 1'b1;
        else               w_acnt_nxt = r_acnt + 1'b1;
      end
    end
    if (w_vs_edge) begin
      w_ycnt_nxt = (w_hs_edge && w_line_act) ? {{(CW-1){1'b0}}, 1'b1} : '0;
      w_vcnt_nxt = {{(CW-1){1'b0}}, w_hs_edge};
    end
  end

  assign w_csum_nxt  = w_vs_edge ? (w_pix ? w_pix_sum : 32'd0)
                                 : (w_pix ? r_csum + w_pix_sum : r_csum);
  assign w_frame_ovf = r_frame_ovf | w_sat;
  assign w_same      = (r_line_h == h_total) && (r_line_a == h_active) &&
                       (r_vcnt == v_total) && (r_ycnt == v_active);
  assign w_qual      = w_same & r_have_prev & ~w_frame_ovf;

  always_ff @(posedge clock) begin
    if (!reset) r_state <= SEEK;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SEEK:    if (w_vs_edge) w_state_nxt = ACQ;
      ACQ:     if (w_vs_edge && w_qual) w_state_nxt = LOCK;
      LOCK:    if (w_vs_edge && !w_qual) w_state_nxt = ACQ;
      default: w_state_nxt = SEEK;
    endcase
  end

  always_comb begin
    w_latch    = w_vs_edge && (r_state != SEEK);
    w_mismatch = w_vs_edge && (r_state == LOCK) && !w_same;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_hs_prev   <= 1'b1;
      r_vs_prev   <= 1'b1;
      r_hcnt      <= '0;
      r_acnt      <= '0;
      r_ycnt      <= '0;
      r_vcnt      <= '0;
      r_line_h    <= '0;
      r_line_a    <= '0;
      r_csum      <= '0;
      r_frame_ovf <= 1'b0;
      r_have_prev <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_done  <= 1'b0;
      h_total     <= '0;
      h_active    <= '0;
      v_total     <= '0;
      v_active    <= '0;
      checksum    <= '0;
      locked      <= 1'b0;
      mismatch    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      r_hs_prev <= w_hs_lvl;
      r_vs_prev <= w_vs_lvl;
      r_hcnt    <= w_hcnt_nxt;
      r_acnt    <= w_acnt_nxt;
      r_ycnt    <= w_ycnt_nxt;
      r_vcnt    <= w_vcnt_nxt;
      r_csum    <= w_csum_nxt;
      if (w_hs_edge) begin
        r_line_h <= r_hcnt;
        if (w_line_act) r_line_a <= r_acnt;
      end
      r_frame_ovf <= w_vs_edge ? 1'b0 : w_frame_ovf;
      overflow    <= overflow | w_sat;

      pix_valid <= w_pix && (r_state != SEEK);
      if (w_pix && (r_state != SEEK)) begin
        pix_x <= w_hs_edge ? '0 : r_acnt;
        pix_y <= w_ycnt_nxt;
      end

      frame_done <= w_latch;
      mismatch   <= w_mismatch;
      locked     <= (w_state_nxt == LOCK);
      if (w_latch) begin
        h_total     <= r_line_h;
        h_active    <= r_line_a;
        v_total     <= r_vcnt;
        v_active    <= r_ycnt;
        checksum    <= r_csum;
        // A saturated frame cannot serve as the reference for the next one.
        r_have_prev <= ~w_frame_ovf;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_sink.sv
// Bench for vga_timing_sink: synthetic frames from a table, scoreboarded pixels and frame reports.
module tb_vga_timing_sink;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [9:0]  red = '0, green = '0, blue = '0;
  logic        pxlen = 1'b0;
  logic        active = 1'b0;
  logic        pix_valid, frame_done, locked, mismatch, overflow;
  logic [11:0] pix_x, pix_y, h_total, h_active, v_total, v_active;
  logic [31:0] checksum;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int L; int P; int r; int g; int b;
    int ht; int cs; bit lk; bit mm;
  } row_t;

  typedef struct {
    logic [11:0] ht, ha, vt, va;
    logic [31:0] cs;
    logic lk, mm;
  } fexp_t;

  typedef struct {
    logic [11:0] x, y;
  } pexp_t;

  fexp_t fq[$];
  pexp_t pq[$];
  bit    model_seek;
  row_t  rows[8];

  vga_timing_sink #(.CDW(10), .CW(12), .SYNC_ACTIVE_LOW(1'b1)) dut (
    .clock(clock), .reset(reset), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue), .pxlen(pxlen), .active(active),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .frame_done(frame_done),
    .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
    .checksum(checksum), .locked(locked), .mismatch(mismatch), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 0);
    chk({tag, "_pix_x"}, 32'(pix_x), 0);
    chk({tag, "_pix_y"}, 32'(pix_y), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_h_total"}, 32'(h_total), 0);
    chk({tag, "_h_active"}, 32'(h_active), 0);
    chk({tag, "_v_total"}, 32'(v_total), 0);
    chk({tag, "_v_active"}, 32'(v_active), 0);
    chk({tag, "_checksum"}, checksum, 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_mismatch"}, 32'(mismatch), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
  endtask

  // One clock of stimulus, given asserted-level syncs; syncs are active-low on the wire.
  task automatic cyc(input bit hs_a, input bit vs_a, input bit pe, input bit act,
                     input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    hsync = ~hs_a; vsync = ~vs_a; pxlen = pe; active = act;
    red = r; green = g; blue = b;
    @(posedge clock); #1;
  endtask

  // Lines 0..7, hsync on pixels 0-1, active pixels 2..7 on lines 0..4, vsync from line 6 pixel 4.
  task automatic run_frame(input int L, input int P, input logic [9:0] r, input logic [9:0] g,
                           input logic [9:0] b, input int l0, input int l1, input fexp_t fe);
    for (int ln = l0; ln <= l1; ln++)
      for (int px = 0; px < L; px++)
        for (int c = 0; c < P; c++) begin
          bit    hs_a, vs_a, act, pe;
          pexp_t p;
          hs_a = (px < 2);
          vs_a = (ln == 6 && px >= 4) || (ln == 7 && px < 4);
          act  = (ln <= 4) && (px >= 2) && (px <= 7);
          pe   = (c == 0);
          if (ln == 6 && px == 4 && c == 0) begin
            if (model_seek) model_seek = 1'b0;
            else            fq.push_back(fe);
          end
          if (pe && act && !model_seek) begin
            p.x = 12'(px - 2);
            p.y = 12'(ln);
            pq.push_back(p);
          end
          cyc(hs_a, vs_a, pe, act, r, g, b);
        end
  endtask

  function automatic row_t mk(int L, int P, int r, int g, int b, int ht, int cs, bit lk, bit mm);
    row_t t;
    t.L = L; t.P = P; t.r = r; t.g = g; t.b = b;
    t.ht = ht; t.cs = cs; t.lk = lk; t.mm = mm;
    return t;
  endfunction

  function automatic fexp_t mkf(int ht, int cs, bit lk, bit mm);
    fexp_t f;
    f.ht = 12'(ht); f.ha = 12'd6; f.vt = 12'd8; f.va = 12'd5;
    f.cs = 32'(cs); f.lk = lk; f.mm = mm;
    return f;
  endfunction

  always @(negedge clock) begin
    if (pix_valid) begin
      if (pq.size() == 0) chk("pix_valid_unexpected", 32'(pix_valid), 0);
      else begin
        pexp_t e;
        e = pq.pop_front();
        chk("pix_x", 32'(pix_x), 32'(e.x));
        chk("pix_y", 32'(pix_y), 32'(e.y));
      end
    end
    if (frame_done) begin
      if (fq.size() == 0) chk("frame_done_unexpected", 32'(frame_done), 0);
      else begin
        fexp_t e;
        e = fq.pop_front();
        chk("h_total", 32'(h_total), 32'(e.ht));
        chk("h_active", 32'(h_active), 32'(e.ha));
        chk("v_total", 32'(v_total), 32'(e.vt));
        chk("v_active", 32'(v_active), 32'(e.va));
        chk("checksum", checksum, e.cs);
        chk("locked", 32'(locked), 32'(e.lk));
        chk("mismatch", 32'(mismatch), 32'(e.mm));
      end
    end
    if (mismatch && !frame_done) chk("mismatch_without_frame_done", 32'(mismatch), 0);
  end

  initial begin
    rows[0] = mk(10, 1, 1, 2, 3, 0, 0, 0, 0);
    rows[1] = mk(10, 1, 1, 2, 3, 10, 180, 0, 0);
    rows[2] = mk(10, 1, 1, 2, 3, 10, 180, 1, 0);
    rows[3] = mk(11, 1, 1, 2, 3, 11, 180, 0, 1);
    rows[4] = mk(11, 1, 1, 2, 3, 11, 180, 1, 0);
    rows[5] = mk(11, 1, 7, 100, 1023, 11, 33900, 1, 0);
    rows[6] = mk(10, 4, 1, 2, 3, 10, 180, 0, 1);
    rows[7] = mk(10, 4, 1, 2, 3, 10, 180, 1, 0);

    model_seek = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          10'($urandom), 10'($urandom), 10'($urandom));
    check_zero("reset");
    reset = 1'b1;

    for (int i = 0; i < 8; i++)
      run_frame(rows[i].L, rows[i].P, 10'(rows[i].r), 10'(rows[i].g), 10'(rows[i].b),
                0, 7, mkf(rows[i].ht, rows[i].cs, rows[i].lk, rows[i].mm));
    chk("pix_queue_drained_table", 32'(pq.size()), 0);
    chk("frame_queue_drained_table", 32'(fq.size()), 0);

    // Reset partway through a frame, between active lines.
    run_frame(10, 1, 10'd1, 10'd2, 10'd3, 0, 2, mkf(0, 0, 0, 0));
    reset = 1'b0;
    cyc(0, 0, 0, 0, 10'd0, 10'd0, 10'd0);
    cyc(0, 0, 0, 0, 10'd0, 10'd0, 10'd0);
    check_zero("midreset");
    pq.delete();
    fq.delete();
    model_seek = 1'b1;
    reset = 1'b1;
    run_frame(10, 1, 10'd1, 10'd2, 10'd3, 3, 7, mkf(0, 0, 0, 0));
    run_frame(10, 1, 10'd1, 10'd2, 10'd3, 0, 7, mkf(10, 180, 0, 0));
    run_frame(10, 1, 10'd1, 10'd2, 10'd3, 0, 7, mkf(10, 180, 1, 0));
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 10'd0, 10'd0, 10'd0);
    chk("pix_queue_drained_reset", 32'(pq.size()), 0);
    chk("frame_queue_drained_reset", 32'(fq.size()), 0);
    chk("overflow_before_sat", 32'(overflow), 0);

    // A line with no hsync runs the pixel counter into saturation.
    for (int i = 0; i < 4200; i++) cyc(0, 0, 1, 0, 10'd0, 10'd0, 10'd0);
    chk("overflow_after_sat", 32'(overflow), 1);
    cyc(0, 0, 0, 0, 10'd0, 10'd0, 10'd0);
    chk("overflow_sticky", 32'(overflow), 1);
    reset = 1'b0;
    cyc(0, 0, 0, 0, 10'd0, 10'd0, 10'd0);
    chk("overflow_cleared_by_reset", 32'(overflow), 0);
    reset = 1'b1;
    cyc(0, 0, 0, 0, 10'd0, 10'd0, 10'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
